// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - ALU op codes and execute-stage FSM encoding shared with ALU_Control
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_MFHI = 4'b1010;
  localparam logic [3:0] ALU_MFLO = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add unsigned multiplier, one step per clock
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH:0]   sum_d;

  // hi_o/lo_o expose the post-step values so the owner can capture the product on the last edge
  always_comb begin
    sum_d  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    hi_o   = sum_d[WIDTH:1];
    lo_o   = {sum_d[0], mplier_q[WIDTH-1:1]};
    last_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= mcand_i;
      acc_q    <= '0;
      mplier_q <= mplier_i;
    end else if (busy_q) begin
      acc_q    <= hi_o;
      mplier_q <= lo_o;
      cnt_q    <= cnt_q + 1'b1;
      if (last_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute stage: single-cycle ALU ops plus iterative MULT into HI/LO
module alu_exec_unit
  import mips_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit Z_ON_UNDEF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             op_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q;
  logic             valid_out_q, zero_q, overflow_q, op_err_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic [WIDTH-1:0] res_d, sum_d, diff_d, mul_hi, mul_lo;
  logic             ovf_d, err_d, mul_last, mul_start;

  assign ready     = (state_q == ST_IDLE);
  assign mul_start = valid_in && ready && (ALUOperation == ALU_MULT);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .mcand_i  (a),
    .mplier_i (b),
    .last_o   (mul_last),
    .hi_o     (mul_hi),
    .lo_o     (mul_lo)
  );

  always_comb begin
    res_d  = '0;
    ovf_d  = 1'b0;
    err_d  = 1'b0;
    sum_d  = a + b;
    diff_d = a - b;
    case (ALUOperation)
      ALU_AND:  res_d = a & b;
      ALU_OR:   res_d = a | b;
      ALU_ADD: begin
        res_d = sum_d;
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = diff_d;
        ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_d[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR:  res_d = ~(a | b);
      ALU_MULT: res_d = result_q;
      ALU_MFHI: res_d = hi_q;
      ALU_MFLO: res_d = lo_q;
      default: begin
        err_d = 1'b1;
        res_d = Z_ON_UNDEF ? '0 : result_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      valid_out_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      op_err_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      valid_out_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mul_start) begin
            state_q <= ST_MUL;
          end else if (valid_in) begin
            result_q    <= res_d;
            zero_q      <= (res_d == '0);
            overflow_q  <= ovf_d;
            op_err_q    <= err_d;
            valid_out_q <= 1'b1;
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            hi_q        <= mul_hi;
            lo_q        <= mul_lo;
            result_q    <= mul_lo;
            zero_q      <= ({mul_hi, mul_lo} == '0);
            overflow_q  <= 1'b0;
            op_err_q    <= 1'b0;
            valid_out_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_out = valid_out_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign op_err    = op_err_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage directly downstream of ALU_Control: consumes the 4-bit ALUOperation code plus two 32-bit operands and produces the result, zero and overflow flags.
- Single-cycle ops complete in 1 clock with a registered result.
- Adds an iterative 32-step unsigned multiplier writing HI/LO, read back by MFHI/MFLO codes.
- A valid/ready handshake lets the datapath stall while a multiply is in progress.

Parameters:
- WIDTH, 32, operand/result width; MUL_STEPS = WIDTH.
- Z_ON_UNDEF, 1, if 1 an undefined op drives result 0; if 0 it holds the previous result.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  operation request
- ready  out  1  high when an op can be accepted (state IDLE)
- ALUOperation  in  4  op code from ALU_Control
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt or sign-extended immediate)
- valid_out  out  1  1-cycle pulse, result/flags valid
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow, ADD/SUB only
- op_err  out  1  undefined op code seen
- hi  out  WIDTH  upper multiply product
- lo  out  WIDTH  lower multiply product

Behaviour:
- Reset: clk and rst are a single clock with synchronous, active-high reset. On reset, state=IDLE, ready=1 (follows from IDLE), and all other outputs are 0: valid_out, result, zero, overflow, op_err, hi, lo.
- Accept: an op is accepted on a rising edge where valid_in && ready. If valid_in is high while ready=0, the request is ignored; upstream holds it.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 SLT: signed compare; result = {31'b0, a<b}.
  - 1100 NOR.
  - 1000 MULT: unsigned.
  - 1010 MFHI: result = hi. 1011 MFLO: result = lo.
  - Any other code, including X/Z: undefined.
- Single-cycle ops, latency 1:
  - On the accept edge, register result, zero, overflow and op_err; valid_out=1 in the following cycle only.
  - State stays IDLE, so back-to-back accepts are allowed every cycle.
- Overflow:
  - ADD: a[31]==b[31] && sum[31]!=a[31].
  - SUB: a[31]!=b[31] && diff[31]!=a[31].
  - All other ops: 0. Wrapped sum/difference is still written to result.
- Undefined op: op_err=1, overflow=0, valid_out pulses. result=0 if Z_ON_UNDEF=1, else result holds its previous value. zero is computed from the registered result.
- FSM states IDLE, MUL, DONE:
  - IDLE -> MUL on an accepted MULT. Load mcand=a, mplier=b, acc=0, cnt=0.
  - MUL: each edge performs one shift-add step: if mplier[0], acc += mcand (WIDTH+1 bits). {acc, mplier} shifts right 1; cnt++.
  - MUL -> DONE on the edge completing step 31 (cnt==31). The same edge writes hi=acc and lo=mplier (final shifted values), result=lo, overflow=0, op_err=0, and zero = (full 64-bit product==0).
  - DONE: valid_out=1 for this one cycle. Next edge -> IDLE.
  - Timing: accept edge E0, steps on E1..E32, valid_out high in the cycle after E32, ready returns in the cycle after E33.
- ready = (state==IDLE). hi and lo change only at MUL completion or reset.
- MFHI/MFLO issued in the cycle ready returns reads the new hi/lo.
- Reset mid-MULT: abort to IDLE, hi/lo cleared, no valid_out pulse.
- Simultaneous rst and valid_in: reset wins; the op is dropped.
- No combinational path from valid_in to ready.

Decomposition:
- Shared package mips_alu_pkg holds:
  - op code localparams: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100, ALU_MULT=4'b1000, ALU_MFHI=4'b1010, ALU_MFLO=4'b1011;
  - state encoding (IDLE, MUL, DONE).
- ALU_Control imports the same op constants.
- One sub-module, seq_multiplier: shift-add datapath with start/done, owning the counter and acc/mplier registers. alu_exec_unit keeps the FSM, the combinational ops and the output registers.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000 and overflow=1, valid_out for exactly 1 cycle after accept; SUB a=5, b=5 -> result=0, zero=1, overflow=0.
- SLT a=0xFFFFFFFF (-1), b=1 -> result=1. AND 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000. NOR 0, 0 -> 0xFFFFFFFF. Issue on back-to-back cycles -> 3 consecutive valid_out pulses.
- MULT a=0xFFFFFFFF, b=2 -> ready=0 for 33 cycles, valid_out in the cycle after E32, hi=0x00000001, lo=0xFFFFFFFE, result=0xFFFFFFFE. Then MFHI -> 1 and MFLO -> 0xFFFFFFFE, each with latency 1.
- valid_in held with ADD 3+4 during a MULT -> ignored while ready=0; accepted on the first cycle ready=1 -> result=7, exactly one valid_out for it.
- rst asserted at step 10 of MULT 6*7 -> next cycle state IDLE, ready=1, hi=lo=0, no valid_out. A fresh MULT 6*7 then gives lo=42, hi=0.
- ALUOperation=4'b1111 (and 4'bxxxx) with Z_ON_UNDEF=1 -> op_err=1, result=0, zero=1, valid_out pulses, no state change.
